// File: rtl/exp4_defs.sv
// Shared definitions for the exp4 control unit: state codes, output bundle and
// the default timeout length, used by the RTL and the testbench alike.
package exp4_defs;

   localparam int TIMEOUT_CICLOS_DEF = 5000;

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARACAO    = 4'h1,
      ESPERA_JOGADA = 4'h2,
      REGISTRA      = 4'h4,
      COMPARACAO    = 4'h5,
      PROXIMO       = 4'h6,
      FIM_ACERTO    = 4'hA,
      FIM_TIMEOUT   = 4'hD,
      FIM_ERRO      = 4'hE
   } estado_t;

   typedef struct packed {
      logic zeraC;
      logic contaC;
      logic zeraR;
      logic registraR;
      logic pronto;
      logic acertou;
      logic errou;
      logic timeout;
   } saidas_t;

   // Moore output table: everything the datapath sees is a function of the state.
   function automatic saidas_t decodifica(estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARACAO: begin
            s.zeraC = 1'b1;
            s.zeraR = 1'b1;
         end
         REGISTRA:   s.registraR = 1'b1;
         PROXIMO:    s.contaC    = 1'b1;
         FIM_ACERTO: begin
            s.pronto  = 1'b1;
            s.acertou = 1'b1;
         end
         FIM_ERRO: begin
            s.pronto = 1'b1;
            s.errou  = 1'b1;
         end
         FIM_TIMEOUT: begin
            s.pronto  = 1'b1;
            s.timeout = 1'b1;
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/exp4_contador_timeout.sv
// Wait-for-entry timer: counts cycles while enabled and flags the last allowed
// cycle; it saturates there so it can never wrap back to zero.
module exp4_contador_timeout
   import exp4_defs::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (zera)
         cnt_d = '0;
      else if (conta && (cnt_q != ULTIMO))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign fim = (cnt_q == ULTIMO);

endmodule

// File: rtl/exp4_unidade_controle.sv
// Control unit for the memory-sequence game round: waits for key entries,
// compares each against memory and ends in hit, miss or timeout.
module exp4_unidade_controle
   import exp4_defs::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   estado_t estado_q, estado_d;
   saidas_t saidas_q;
   logic    to_zera, to_conta, to_fim;

   // The wait timer restarts on every new entry, so PROXIMO clears it as well.
   assign to_zera  = (estado_q == PREPARACAO) || (estado_q == PROXIMO);
   assign to_conta = (estado_q == ESPERA_JOGADA);

   exp4_contador_timeout #(
      .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
   ) u_timeout (
      .clock(clock),
      .reset(reset),
      .zera (to_zera),
      .conta(to_conta),
      .fim  (to_fim)
   );

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:       if (iniciar) estado_d = PREPARACAO;
         PREPARACAO:    estado_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            // A key press on the terminal cycle still counts as an entry.
            if (jogada)
               estado_d = REGISTRA;
            else if (to_fim)
               estado_d = FIM_TIMEOUT;
         end
         REGISTRA:      estado_d = COMPARACAO;
         COMPARACAO: begin
            if (!igual)
               estado_d = FIM_ERRO;
            else if (fimC)
               estado_d = FIM_ACERTO;
            else
               estado_d = PROXIMO;
         end
         PROXIMO:       estado_d = ESPERA_JOGADA;
         FIM_ACERTO,
         FIM_ERRO,
         FIM_TIMEOUT:   if (iniciar) estado_d = PREPARACAO;
         default:       estado_d = INICIAL;
      endcase
   end

   // Outputs are registered from the next state so they line up with estado_q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= INICIAL;
         saidas_q <= '0;
      end else begin
         estado_q <= estado_d;
         saidas_q <= decodifica(estado_d);
      end
   end

   assign zeraC     = saidas_q.zeraC;
   assign contaC    = saidas_q.contaC;
   assign zeraR     = saidas_q.zeraR;
   assign registraR = saidas_q.registraR;
   assign pronto    = saidas_q.pronto;
   assign acertou   = saidas_q.acertou;
   assign errou     = saidas_q.errou;
   assign timeout   = saidas_q.timeout;
   assign db_estado = estado_q;

endmodule

// File: doc/exp4_unidade_controle.md
EXP4_UNIDADE_CONTROLE -- requirements
Module: exp4_unidade_controle

Interface
REQ-001 Parameter: TIMEOUT_CICLOS, 5000, clock cycles allowed in ESPERA_JOGADA before timeout (>=2).
REQ-002 Port: clock  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 Port: iniciar  input  1  start or restart request, level-sampled.
REQ-005 Port: jogada  input  1  one-cycle pulse from the datapath edge detector: a new key entry is present.
REQ-006 Port: igual  input  1  datapath comparator: registered chaves equal memory word.
REQ-007 Port: fimC  input  1  address counter at last address.
REQ-008 Port: zeraC, contaC, zeraR, registraR  output  1 each  datapath counter and register controls.
REQ-009 Port: pronto  output  1  round finished.
REQ-010 Port: acertou, errou, timeout  output  1 each  result flags, mutually exclusive.
REQ-011 Port: db_estado  output  4  current state code for the hex display.

Function
REQ-012 Moore FSM; all outputs SHALL be decoded from the current state only.
REQ-013 State codes: INICIAL 0x0, PREPARACAO 0x1, ESPERA_JOGADA 0x2, REGISTRA 0x4, COMPARACAO 0x5, PROXIMO 0x6, FIM_ACERTO 0xA, FIM_TIMEOUT 0xD, FIM_ERRO 0xE; db_estado SHALL equal the code.
REQ-014 INICIAL: all control and result outputs 0; iniciar=1 -> PREPARACAO, else stay.
REQ-015 PREPARACAO: zeraC=1, zeraR=1, timeout counter cleared; unconditional -> ESPERA_JOGADA after 1 cycle.
REQ-016 ESPERA_JOGADA: timeout counter increments each cycle; jogada=1 -> REGISTRA; counter reaching TIMEOUT_CICLOS-1 with jogada=0 -> FIM_TIMEOUT.
REQ-017 Simultaneous jogada=1 and timeout terminal count: jogada wins, next state REGISTRA.
REQ-018 REGISTRA: registraR=1 for exactly 1 cycle; -> COMPARACAO.
REQ-019 COMPARACAO: igual=0 -> FIM_ERRO; igual=1 and fimC=1 -> FIM_ACERTO; igual=1 and fimC=0 -> PROXIMO.
REQ-020 PROXIMO: contaC=1 for exactly 1 cycle, timeout counter cleared; -> ESPERA_JOGADA.
REQ-021 FIM_ACERTO/FIM_ERRO/FIM_TIMEOUT: pronto=1 plus acertou/errou/timeout respectively, held; iniciar=1 -> PREPARACAO, else stay.
REQ-022 iniciar SHALL be ignored in all states except INICIAL and the three FIM states; jogada SHALL be ignored outside ESPERA_JOGADA.
REQ-023 Latency: iniciar sampled at edge N -> zeraC/zeraR high during cycle N+1; jogada at edge M -> registraR high during M+1, result decision at M+2.
REQ-024 Unused state codes SHALL transition to INICIAL on the next clock.
REQ-025 Timeout counter width: ceil(log2(TIMEOUT_CICLOS)) bits; no wrap-around possible in ESPERA_JOGADA.

Reset
REQ-026 reset=0 SHALL force INICIAL and clear the timeout counter asynchronously, regardless of clock, including mid-round.
REQ-027 During and after reset: all control/result outputs 0, db_estado=0x0; first transition on the first rising edge after reset returns to 1.

Structure
REQ-028 State codes and TIMEOUT_CICLOS default SHALL live in a shared package/include exp4_defs, reused by the top level and bench.
REQ-029 Timeout counter SHALL be a sub-module exp4_contador_timeout (ports clock, reset, zera, conta, fim), parameterised by TIMEOUT_CICLOS.

Verification (bench with TIMEOUT_CICLOS=10, 16-word memory)
REQ-030 Full correct round: iniciar pulse, 16 jogada pulses with igual=1, fimC=1 on the 16th -> contaC pulses 15 times, FIM_ACERTO, pronto=1, acertou=1, db_estado=0xA.
REQ-031 Error on 3rd entry: igual=0 at 3rd COMPARACAO -> FIM_ERRO, errou=1, pronto=1, db_estado=0xE, contaC pulsed exactly 2 times.
REQ-032 Timeout: no jogada for 10 cycles in ESPERA_JOGADA -> FIM_TIMEOUT, timeout=1, db_estado=0xD; jogada on cycle 10 exactly -> REGISTRA instead.
REQ-033 Async reset mid-round: reset=0 between clock edges while in COMPARACAO -> db_estado=0x0 and all outputs 0 before the next edge.
REQ-034 Restart and ignore: iniciar=1 in FIM_ERRO -> PREPARACAO next cycle; iniciar=1 in ESPERA_JOGADA and jogada=1 in INICIAL -> no state change.
